// File: rtl/bridge_pkg.sv
// -----------------------------------------------------------------------------
// bridge_pkg
// Shared constants for the UART-to-peripheral-bus bridge:
//   - command bytes recognised in the frame header (CMD_WR, CMD_RD)
//   - the response byte sent when a frame is abandoned (TIMEOUT_BYTE)
//   - FSM state encoding (3-bit, legacy-compatible constants)
//   - byte_at(): selects byte idx (0 = bits 7:0) from a 32-bit word
// -----------------------------------------------------------------------------
package bridge_pkg;

    localparam logic [7:0] CMD_WR       = 8'h57;
    localparam logic [7:0] CMD_RD       = 8'h52;
    localparam logic [7:0] TIMEOUT_BYTE = 8'h54;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_BUS  = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    function automatic logic [7:0] byte_at(input logic [31:0] w, input logic [1:0] idx);
        return w[8*idx +: 8];
    endfunction

endpackage

// File: rtl/uart_bus_bridge_if.sv
// -----------------------------------------------------------------------------
// uart_bus_bridge_if
// Peripheral bus between the bridge (master) and the register block (slave).
//   bus_rd    : read strobe, one cycle
//   bus_wr    : write strobe, one cycle (never together with bus_rd)
//   bus_addr  : 32-bit address, valid while a strobe is high
//   bus_wdata : 32-bit write data, valid while bus_wr is high
//   bus_rdata : 32-bit read data, combinational from the slave during bus_rd
// -----------------------------------------------------------------------------
interface uart_bus_bridge_if;

    logic        bus_rd;
    logic        bus_wr;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    modport master (
        output bus_rd,
        output bus_wr,
        output bus_addr,
        output bus_wdata,
        input  bus_rdata
    );

    modport slave (
        input  bus_rd,
        input  bus_wr,
        input  bus_addr,
        input  bus_wdata,
        output bus_rdata
    );

endinterface

// File: rtl/bridge_timeout.sv
// -----------------------------------------------------------------------------
// bridge_timeout
// Idle-cycle counter used to abandon a stalled frame.
//   clk, reset : clock, asynchronous active-low reset
//   clear      : restart the count from zero (has priority over enable)
//   enable     : count one cycle
//   expired    : count has reached TIMEOUT_CYCLES; stays high until clear
// -----------------------------------------------------------------------------
module bridge_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int             CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count;

    assign expired = (count == LIMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_bus_bridge.sv
// -----------------------------------------------------------------------------
// uart_bus_bridge
// Turns command frames from a UART byte receiver into single-cycle peripheral
// bus reads/writes and returns response bytes to a UART byte transmitter.
//   Write frame: 57 A3 A2 A1 A0 D3 D2 D1 D0  -> bus write, response ACK_BYTE
//   Read frame : 52 A3 A2 A1 A0              -> bus read, response rdata MSB first
//   Other first byte                         -> response NAK_BYTE
//
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   rx_data, rx_valid   : received byte, one-cycle strobe, no backpressure
//   tx_data, tx_valid,  : outgoing byte
//   tx_ready
//   bus                 : peripheral bus, master side (uart_bus_bridge_if)
//   busy                : FSM is not in IDLE
//   drop                : an rx byte arrived while a frame was being serviced
//   state_dbg           : current FSM state (bridge_pkg ST_* encoding)
//
// tx handshake: tx_valid rises with a byte and, together with tx_data, holds
// until a posedge where tx_ready=1; that edge transfers the byte.
//
// Optional build macro BRIDGE_TIMEOUT_EN: abandon a frame that sits in
// ADDR/DATA for TIMEOUT_CYCLES without a byte, answering TIMEOUT_BYTE.
// -----------------------------------------------------------------------------
module uart_bus_bridge
    import bridge_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] ACK_BYTE       = 8'h4B,
    parameter logic [7:0] NAK_BYTE       = 8'h3F
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    uart_bus_bridge_if.master  bus,
    output logic               busy,
    output logic               drop,
    output logic [2:0]         state_dbg
);

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [2:0]  state;
    logic        is_rd;
    logic [1:0]  cnt;       // byte index in ADDR/DATA, bytes remaining - 1 in RESP
    logic [31:0] addr_sh;   // address being assembled
    logic [23:0] wdata_sh;  // first three data bytes; the fourth joins on the last strobe
    logic [31:0] addr_q;    // presented on the bus from one BUS cycle to the next
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    assign bus.bus_rd    = (state == ST_BUS) &&  is_rd;
    assign bus.bus_wr    = (state == ST_BUS) && !is_rd;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;

    assign busy      = (state != ST_IDLE);
    assign drop      = rx_valid && ((state == ST_BUS) || (state == ST_RESP));
    assign state_dbg = state;

`ifdef BRIDGE_TIMEOUT_EN
    logic timeout_hit;

    // Held clear in IDLE so the count starts fresh on entry to ADDR.
    bridge_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (rx_valid || (state == ST_IDLE)),
        .enable  ((state == ST_ADDR) || (state == ST_DATA)),
        .expired (timeout_hit)
    );
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            is_rd    <= 1'b0;
            cnt      <= 2'd0;
            addr_sh  <= '0;
            wdata_sh <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        if ((rx_data == CMD_WR) || (rx_data == CMD_RD)) begin
                            is_rd <= (rx_data == CMD_RD);
                            cnt   <= 2'd0;
                            state <= ST_ADDR;
                        end else begin
                            tx_data  <= NAK_BYTE;
                            tx_valid <= 1'b1;
                            cnt      <= 2'd0;
                            state    <= ST_RESP;
                        end
                    end
                end

                ST_ADDR: begin
                    if (rx_valid) begin
                        addr_sh <= {addr_sh[23:0], rx_data};
                        cnt     <= cnt + 2'd1;   // wraps to 0 ready for DATA
                        if (cnt == 2'd3) begin
                            if (is_rd) begin
                                addr_q <= {addr_sh[23:0], rx_data};
                                state  <= ST_BUS;
                            end else begin
                                state  <= ST_DATA;
                            end
                        end
                    end
`ifdef BRIDGE_TIMEOUT_EN
                    else if (timeout_hit) begin
                        tx_data  <= TIMEOUT_BYTE;
                        tx_valid <= 1'b1;
                        cnt      <= 2'd0;
                        state    <= ST_RESP;
                    end
`endif
                end

                ST_DATA: begin
                    if (rx_valid) begin
                        wdata_sh <= {wdata_sh[15:0], rx_data};
                        cnt      <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            addr_q  <= addr_sh;
                            wdata_q <= {wdata_sh, rx_data};
                            state   <= ST_BUS;
                        end
                    end
`ifdef BRIDGE_TIMEOUT_EN
                    else if (timeout_hit) begin
                        tx_data  <= TIMEOUT_BYTE;
                        tx_valid <= 1'b1;
                        cnt      <= 2'd0;
                        state    <= ST_RESP;
                    end
`endif
                end

                ST_BUS: begin
                    tx_valid <= 1'b1;
                    state    <= ST_RESP;
                    if (is_rd) begin
                        rdata_q <= bus.bus_rdata;
                        tx_data <= bus.bus_rdata[31:24];
                        cnt     <= 2'd3;
                    end else begin
                        tx_data <= ACK_BYTE;
                        cnt     <= 2'd0;
                    end
                end

                ST_RESP: begin
                    if (tx_valid && tx_ready) begin
                        if (cnt == 2'd0) begin
                            tx_valid <= 1'b0;
                            state    <= ST_IDLE;
                        end else begin
                            cnt     <= cnt - 2'd1;
                            tx_data <= byte_at(rdata_q, cnt - 2'd1);
                        end
                    end
                end

                default: begin
                    tx_valid <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_uart_bus_bridge
// Directed frames into uart_bus_bridge; a frame-level model predicts the bus
// transaction and response bytes, and a negedge compare process checks them.
// -----------------------------------------------------------------------------
module tb_uart_bus_bridge;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        busy;
    logic        drop;
    logic [2:0]  state_dbg;
    logic [31:0] rdata_val = 32'h0;

    uart_bus_bridge_if bus_if ();

    // Peripheral responder: data is only meaningful during bus_rd.
    assign bus_if.bus_rdata = bus_if.bus_rd ? rdata_val : 32'hDEAD_BEEF;

    uart_bus_bridge #(
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .bus       (bus_if),
        .busy      (busy),
        .drop      (drop),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [7:0]  exp_tx_q[$];
    logic [64:0] exp_bus_q[$];   // {is_write, addr, wdata}
    int n_checks = 0;
    int n_pass = 0;
    int drops_seen = 0;
    int strobe_cyc = -1;
    int tx_first_cyc = -1;
    int last_edge = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- model ----------------
    logic [7:0] fb [0:8];

    task automatic model_frame(input int n);
        logic [31:0] a;
        logic [31:0] d;
        a = {fb[1], fb[2], fb[3], fb[4]};
        d = {fb[5], fb[6], fb[7], fb[8]};
        if (fb[0] == 8'h57 && n == 9) begin
            exp_bus_q.push_back({1'b1, a, d});
            exp_tx_q.push_back(8'h4B);
        end else if (fb[0] == 8'h52 && n == 5) begin
            exp_bus_q.push_back({1'b0, a, 32'h0});
            for (int i = 3; i >= 0; i--) exp_tx_q.push_back(8'((rdata_val >> (8 * i)) & 32'hFF));
        end else if (n == 1) begin
            exp_tx_q.push_back(8'h3F);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rx_data  = fb[i];
            rx_valid = 1'b1;
        end
        @(posedge clk); #1;
        last_edge = cyc;
        rx_valid  = 1'b0;
    endtask

    task automatic drive_one(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        k = 0;
        while ((exp_tx_q.size() != 0 || busy) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({name, "_completes"}, 32'(k < budget), 32'd1);
        check({name, "_bus_consumed"}, 32'(exp_bus_q.size()), 32'd0);
    endtask

    // 0: always ready, 1: ready after 3 low cycles per byte, 2: held low
    int ready_mode = 0;
    int stall_cnt = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: tx_ready = 1'b1;
            2: tx_ready = 1'b0;
            default: begin
                if (tx_ready) begin
                    tx_ready  = 1'b0;
                    stall_cnt = 0;
                end else if (tx_valid) begin
                    stall_cnt++;
                    if (stall_cnt == 3) tx_ready = 1'b1;
                end
            end
        endcase
    end

    // ---------------- compare process ----------------
    logic        prev_valid = 1'b0;
    logic        prev_acc = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    logic [64:0] e;

    always @(negedge clk) begin
        if (!reset) begin
            prev_valid = 1'b0;
            prev_acc   = 1'b0;
        end else begin
            if (bus_if.bus_rd && bus_if.bus_wr) check("rd_wr_exclusive", 32'd1, 32'd0);
            if (bus_if.bus_rd || bus_if.bus_wr) begin
                strobe_cyc = cyc;
                if (exp_bus_q.size() == 0) begin
                    check("unexpected_bus_strobe", 32'({bus_if.bus_rd, bus_if.bus_wr}), 32'd0);
                end else begin
                    e = exp_bus_q.pop_front();
                    check("bus_is_write", 32'(bus_if.bus_wr), 32'(e[64]));
                    check("bus_addr", bus_if.bus_addr, e[63:32]);
                    if (e[64]) check("bus_wdata", bus_if.bus_wdata, e[31:0]);
                end
            end
            if (tx_valid && !prev_valid) tx_first_cyc = cyc;
            if (tx_valid && prev_valid && !prev_acc) check("tx_data_stable", 32'(tx_data), 32'(prev_data));
            if (tx_valid && tx_ready) begin
                if (exp_tx_q.size() == 0) check("unexpected_tx_byte", 32'(tx_data), 32'hFFFF_FFFF);
                else check("tx_byte", 32'(tx_data), 32'(exp_tx_q.pop_front()));
            end
            if (drop) drops_seen++;
            prev_valid = tx_valid;
            prev_acc   = tx_valid && tx_ready;
            prev_data  = tx_data;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_bus_rd"}, 32'(bus_if.bus_rd), 32'd0);
        check({tag, "_bus_wr"}, 32'(bus_if.bus_wr), 32'd0);
        check({tag, "_bus_addr"}, bus_if.bus_addr, 32'd0);
        check({tag, "_bus_wdata"}, bus_if.bus_wdata, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_drop"}, 32'(drop), 32'd0);
        check({tag, "_state"}, 32'(state_dbg), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int d0;
        int k;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b1;

        // Write with tx always ready
        ready_mode = 0;
        fb = '{8'h57, 8'h40, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 8'hA5};
        model_frame(9);
        check("model_wr_addr", exp_bus_q[0][63:32], 32'h4000_000C);
        check("model_wr_data", exp_bus_q[0][31:0], 32'h0000_00A5);
        check("model_wr_ack", 32'(exp_tx_q[0]), 32'h4B);
        drive_bytes(9);
        wait_done("write", 50);
        check("wr_strobe_latency", 32'(strobe_cyc - last_edge), 32'd0);
        check("wr_tx_latency", 32'(tx_first_cyc - last_edge), 32'd1);
        check("busy_after_write", 32'(busy), 32'd0);

        // Read with tx stalled 3 cycles per byte
        ready_mode = 1;
        rdata_val = 32'h0000_003C;
        fb = '{8'h52, 8'h40, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
        model_frame(5);
        check("model_rd_addr", exp_bus_q[0][63:32], 32'h4000_0010);
        check("model_rd_last", 32'(exp_tx_q[3]), 32'h3C);
        drive_bytes(5);
        wait_done("read_stall", 100);
        check("rd_strobe_latency", 32'(strobe_cyc - last_edge), 32'd0);

        // Unknown command, then a normal read
        ready_mode = 0;
        fb[0] = 8'h41;
        model_frame(1);
        check("model_nak", 32'(exp_tx_q[0]), 32'h3F);
        drive_bytes(1);
        wait_done("unknown", 20);
        rdata_val = 32'h1234_5678;
        fb = '{8'h52, 8'h40, 8'h00, 8'h00, 8'h18, 8'h00, 8'h00, 8'h00, 8'h00};
        model_frame(5);
        drive_bytes(5);
        wait_done("read_after_nak", 30);

        // Reset mid-frame, then a full write
        fb = '{8'h57, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        drive_bytes(3);
        reset = 1'b0;
        #2;
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        reset = 1'b1;
        fb = '{8'h57, 8'h40, 8'h00, 8'h00, 8'h14, 8'h00, 8'h00, 8'h0F, 8'hFF};
        model_frame(9);
        drive_bytes(9);
        wait_done("write_after_reset", 50);

        // Overrun: bytes arriving while the response waits on tx_ready
        ready_mode = 2;
        rdata_val = 32'hA1B2_C3D4;
        fb = '{8'h52, 8'h40, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00};
        model_frame(5);
        drive_bytes(5);
        k = 0;
        while (!tx_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("overrun_tx_presented", 32'(tx_valid), 32'd1);
        d0 = drops_seen;
        drive_one(8'h11);
        drive_one(8'h22);
        repeat (2) @(negedge clk);
        check("overrun_drop_pulses", 32'(drops_seen - d0), 32'd2);
        check("overrun_tx_held", 32'(tx_data), 32'hA1);
        ready_mode = 0;
        wait_done("overrun", 40);

`ifdef BRIDGE_TIMEOUT_EN
        // Stalled frame is abandoned with the timeout byte
        fb = '{8'h57, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_tx_q.push_back(8'h54);
        drive_bytes(2);
        wait_done("timeout", 300);
        check("busy_after_timeout", 32'(busy), 32'd0);
`else
        // Stalled frame waits indefinitely
        fb = '{8'h57, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        drive_bytes(2);
        repeat (150) @(negedge clk);
        check("stalled_still_busy", 32'(busy), 32'd1);
        check("stalled_no_tx", 32'(tx_valid), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
`endif

        check("total_drops", 32'(drops_seen), 32'd2);
        check("tx_queue_empty", 32'(exp_tx_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global guard against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
